// File: rtl/load_store_unit.sv
// Load/store unit: sequences one memory access per request with lane steering and timeout.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module load_store_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [1:0]  bit_half_word_select,
  input  logic        is_unsigned,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    FAULT
  } state_t;

  state_t        state_q;
  logic          st_q;
  logic [1:0]    lo_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          fault_q;
  logic [31:0]   ld_q;
  logic          mreq_q;
  logic          mwe_q;
  logic [31:0]   maddr_q;
  logic [31:0]   mwdata_q;
  logic [3:0]    mbe_q;

  logic [1:0]    lo_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic          trap_d;
  logic [31:0]   ld_d;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    lo_d   = addr[1:0];
    trap_d = 1'b0;
    if (bit_half_word_select == 2'b01)
      trap_d = addr[0];
    else if (bit_half_word_select[1])
      trap_d = |addr[1:0];
  end
`else
  // Misaligned requests are forced onto their natural boundary.
  always_comb begin
    trap_d = 1'b0;
    lo_d   = addr[1:0];
    if (bit_half_word_select == 2'b01)
      lo_d = {addr[1], 1'b0};
    else if (bit_half_word_select[1])
      lo_d = 2'b00;
  end
`endif

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = store_data;
    unique case (1'b1)
      bit_half_word_select == 2'b00: begin
        be_d    = 4'b0001 << lo_d;
        wdata_d = {4{store_data[7:0]}};
      end
      bit_half_word_select == 2'b01: begin
        be_d    = lo_d[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = store_data;
      end
    endcase
    if (!is_store)
      be_d = 4'b0000;
  end

  always_comb begin
    ld_b = mem_rdata[{lo_q, 3'b000} +: 8];
    ld_h = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ld_d = mem_rdata;
    unique case (1'b1)
      size_q == 2'b00:
        ld_d = {{24{~uns_q & ld_b[7]}}, ld_b};
      size_q == 2'b01:
        ld_d = {{16{~uns_q & ld_h[15]}}, ld_h};
      default:
        ld_d = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      st_q     <= 1'b0;
      lo_q     <= 2'b00;
      size_q   <= 2'b00;
      uns_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      ld_q     <= '0;
      mreq_q   <= 1'b0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      mbe_q    <= 4'b0000;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            st_q   <= is_store;
            lo_q   <= lo_d;
            size_q <= bit_half_word_select;
            uns_q  <= is_unsigned;
            busy_q <= 1'b1;
            if (trap_d) begin
              state_q <= FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else begin
              state_q  <= ACCESS;
              cnt_q    <= '0;
              mreq_q   <= 1'b1;
              mwe_q    <= is_store;
              maddr_q  <= {addr[31:2], 2'b00};
              mwdata_q <= wdata_d;
              mbe_q    <= be_d;
            end
          end
        end
        ACCESS: begin
          // A late mem_ready wins over an expiring timeout.
          if (mem_ready) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            mbe_q   <= 4'b0000;
            if (!st_q)
              ld_q <= ld_d;
          end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
            state_q <= FAULT;
            cnt_q   <= cnt_q + CW'(1);
            done_q  <= 1'b1;
            fault_q <= 1'b1;
            mreq_q  <= 1'b0;
            mwe_q   <= 1'b0;
            mbe_q   <= 4'b0000;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE, FAULT: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          fault_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign load_data = ld_q;
  assign mem_req   = mreq_q;
  assign mem_we    = mwe_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign mem_be    = mbe_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: scoreboard of expected completions, checked on done.
// Expected load values assume the default (force-align) build.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [1:0]  sel;
  logic        is_unsigned;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        flt;
    logic [31:0] ld;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_m;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] last_ld;

  load_store_unit #(.MEM_TIMEOUT(TO)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .start                (start),
    .is_store             (is_store),
    .addr                 (addr),
    .store_data           (store_data),
    .bit_half_word_select (sel),
    .is_unsigned          (is_unsigned),
    .busy                 (busy),
    .done                 (done),
    .fault                (fault),
    .load_data            (load_data),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_be               (mem_be),
    .mem_ready            (mem_ready),
    .mem_rdata            (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        e_m = sb.pop_front();
        check("fault", {31'd0, fault}, {31'd0, e_m.flt});
        check("load_data", load_data, e_m.ld);
        check("latency", cyc, e_m.at);
      end
    end
  end

  task automatic op(input logic        st,
                    input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [1:0]  sz,
                    input logic        uns,
                    input int          w,
                    input bit          poke,
                    input logic [31:0] rd,
                    input logic [31:0] exp_ld,
                    input logic [31:0] exp_ma,
                    input logic [3:0]  exp_be,
                    input logic [31:0] exp_wd);
    bit   misal;
    bit   trapped;
    bit   to;
    int   lat;
    exp_t e;
    misal = (sz == 2'b01 && a[0]) ||
            (sz[1] && a[1:0] != 2'b00);
`ifdef LSU_MISALIGN_TRAP_EN
    trapped = misal;
`else
    trapped = 1'b0;
`endif
    to  = !trapped && (w >= TO);
    lat = trapped ? 1 : (to ? TO + 1 : 2 + w);
    @(posedge clk); #1;
    start       = 1'b1;
    is_store    = st;
    addr        = a;
    store_data  = d;
    sel         = sz;
    is_unsigned = uns;
    e.flt = trapped || to;
    e.ld  = (!st && !e.flt) ? exp_ld : last_ld;
    e.at  = cyc + lat;
    last_ld = e.ld;
    sb.push_back(e);
    @(posedge clk); #1;
    start      = 1'b0;
    addr       = $urandom;
    store_data = $urandom;
    sel        = 2'($urandom);
    check("busy", {31'd0, busy}, 32'd1);
    if (trapped) begin
      check("req_trap", {31'd0, mem_req}, 32'd0);
    end else begin
      check("req", {31'd0, mem_req}, 32'd1);
      check("we", {31'd0, mem_we}, {31'd0, st});
      check("maddr", mem_addr, exp_ma);
      check("be", {28'd0, mem_be}, {28'd0, exp_be});
      if (st)
        check("wdata", mem_wdata, exp_wd);
      if (to) begin
        for (int i = 1; i < TO; i++) begin
          @(posedge clk); #1;
          check("req_hold", {31'd0, mem_req}, 32'd1);
        end
        @(posedge clk); #1;
        check("req_drop", {31'd0, mem_req}, 32'd0);
      end else begin
        for (int i = 0; i < w; i++) begin
          if (poke && i == 0) begin
            start    = 1'b1;
            addr     = 32'h0000_0ff0;
            is_store = ~st;
          end
          @(posedge clk); #1;
          start = 1'b0;
          check("req_stall", {31'd0, mem_req}, 32'd1);
          check("maddr_stall", mem_addr, exp_ma);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end
    for (int n = 0; n < 12 && sb.size() != 0; n++)
      @(posedge clk);
    if (sb.size() != 0) begin
      check("done_pending", sb.size(), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    is_store    = 1'b0;
    addr        = '0;
    store_data  = '0;
    sel         = 2'b00;
    is_unsigned = 1'b0;
    mem_ready   = 1'b0;
    mem_rdata   = '0;
    last_ld     = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check("rst_ld", load_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // st, addr, data, size, uns, wait, poke, rdata, ld, maddr, be, wdata
    op(1, 32'h103, 32'hAB, 2'b00, 0, 0, 0, 32'h0,
       32'h0, 32'h100, 4'b1000, 32'hABABABAB);
    op(0, 32'h102, 32'h0, 2'b00, 0, 0, 0, 32'h00F00000,
       32'hFFFFFFF0, 32'h100, 4'b0000, 32'h0);
    op(0, 32'h102, 32'h0, 2'b00, 1, 0, 0, 32'h00F00000,
       32'h000000F0, 32'h100, 4'b0000, 32'h0);
    op(0, 32'h101, 32'h0, 2'b01, 0, 0, 0, 32'h12348765,
       32'hFFFF8765, 32'h100, 4'b0000, 32'h0);
    op(0, 32'h104, 32'h0, 2'b10, 0, TO, 0, 32'h0,
       32'h0, 32'h104, 4'b0000, 32'h0);
    op(1, 32'h102, 32'h1234ABCD, 2'b01, 0, 1, 0, 32'h0,
       32'h0, 32'h100, 4'b1100, 32'hABCDABCD);
    op(1, 32'h200, 32'hDEADBEEF, 2'b10, 0, 0, 0, 32'h0,
       32'h0, 32'h200, 4'b1111, 32'hDEADBEEF);
    op(0, 32'h204, 32'h0, 2'b11, 1, 0, 0, 32'h89ABCDEF,
       32'h89ABCDEF, 32'h204, 4'b0000, 32'h0);
    op(0, 32'h206, 32'h0, 2'b01, 1, 0, 0, 32'h80010000,
       32'h00008001, 32'h204, 4'b0000, 32'h0);
    op(0, 32'h301, 32'h0, 2'b00, 0, 3, 1, 32'h00008000,
       32'hFFFFFF80, 32'h300, 4'b0000, 32'h0);
    op(1, 32'h202, 32'h11223344, 2'b10, 0, 0, 0, 32'h0,
       32'h0, 32'h200, 4'b1111, 32'h11223344);
    op(1, 32'h001, 32'h5A, 2'b00, 0, 2, 0, 32'h0,
       32'h0, 32'h000, 4'b0010, 32'h5A5A5A5A);
    op(0, 32'h10C, 32'h0, 2'b10, 0, TO - 1, 0, 32'hCAFEF00D,
       32'hCAFEF00D, 32'h10C, 4'b0000, 32'h0);

    // Reset in the middle of an access.
    @(posedge clk); #1;
    start       = 1'b1;
    is_store    = 1'b0;
    addr        = 32'h400;
    sel         = 2'b10;
    is_unsigned = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_ld", load_data, 32'd0);
    last_ld = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    op(0, 32'h503, 32'h0, 2'b00, 1, 0, 0, 32'h7F000000,
       32'h0000007F, 32'h500, 4'b0000, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
